// File: rtl/music_box_tone_gen_if.sv
// Song-select / note-timer inputs and tone/sequencer outputs of the music box tone core.
interface music_box_tone_gen_if #(
    parameter int AW    = 5,
    parameter int CNT_W = 20
);
    logic             song1;
    logic             song2;
    logic             song3;
    logic             note_done;
    logic             tone_en;
    logic             kclk;
    logic [CNT_W-1:0] note;
    logic [1:0]       duration;
    logic [AW-1:0]    mem_loc;
    logic [3:0]       notecase;
    logic             start;
    logic             speaker;

    modport master (
        output song1, song2, song3, note_done, tone_en,
        input  kclk, note, duration, mem_loc, notecase, start, speaker
    );

    modport slave (
        input  song1, song2, song3, note_done, tone_en,
        output kclk, note, duration, mem_loc, notecase, start, speaker
    );
endinterface

// File: rtl/music_box_tone_gen.sv
// Music box core: kclk = clk/2, three 32-step songs advanced by note_done, square-wave speaker.
// note/notecase/duration are combinational from mem_loc; speaker toggles every T cycles (T = half period).
module music_box_tone_gen #(
    parameter int SONG_LEN = 32,
    parameter int CNT_W    = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    music_box_tone_gen_if.slave  bus
);
    localparam int AW = $clog2(SONG_LEN);

    typedef enum logic [1:0] {SEL_NONE, SEL_S1, SEL_S2, SEL_S3} sel_e;

    sel_e             sel_d, sel_q;
    logic [AW-1:0]    mem_loc_d, mem_loc_q;
    logic [CNT_W-1:0] tone_cnt_d, tone_cnt_q;
    logic             speaker_d, speaker_q;
    logic             kclk_q;
    logic             start;
    logic [3:0]       step;
    logic [3:0]       notecase;
    logic [1:0]       duration;
    logic [CNT_W-1:0] note;
    logic [CNT_W-1:0] tone_t;

    always_comb begin
        sel_d = SEL_NONE;
        if (bus.song1)      sel_d = SEL_S1;
        else if (bus.song2) sel_d = SEL_S2;
        else if (bus.song3) sel_d = SEL_S3;
    end

    assign start = bus.song1 | bus.song2 | bus.song3;

    // A select change (including to none) restarts the song and swallows that cycle's note_done.
    always_comb begin
        mem_loc_d = mem_loc_q;
        if (sel_d != sel_q || !start)
            mem_loc_d = '0;
        else if (bus.note_done)
            mem_loc_d = (mem_loc_q == AW'(SONG_LEN - 1)) ? '0 : mem_loc_q + 1'b1;
    end

    assign step = mem_loc_q[3:0];

    always_comb begin
        notecase = 4'd0;
        duration = 2'd0;
        case (sel_d)
            SEL_S1: begin
                // Rising 1..8 on steps 0-7, then 8..1 on steps 8-15 (16-step mod 16).
                notecase = step[3] ? (4'd0 - step) : (step + 4'd1);
                duration = 2'd1;
            end
            SEL_S2: begin
                case (step)
                    4'd0, 4'd1, 4'd14: notecase = 4'd1;
                    4'd2, 4'd3, 4'd6:  notecase = 4'd5;
                    4'd4, 4'd5:        notecase = 4'd6;
                    4'd8, 4'd9:        notecase = 4'd4;
                    4'd10, 4'd11:      notecase = 4'd3;
                    4'd12, 4'd13:      notecase = 4'd2;
                    default:           notecase = 4'd0;
                endcase
                if (step == 4'd7 || step == 4'd15)      duration = 2'd3;
                else if (step == 4'd6 || step == 4'd14) duration = 2'd2;
            end
            SEL_S3: begin
                notecase = mem_loc_q[0] ? 4'd3 : 4'd5;
                duration = (mem_loc_q == AW'(SONG_LEN - 1)) ? 2'd3 : 2'd0;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (notecase)
            4'd1:    note = CNT_W'(191109);
            4'd2:    note = CNT_W'(170265);
            4'd3:    note = CNT_W'(151685);
            4'd4:    note = CNT_W'(143172);
            4'd5:    note = CNT_W'(127550);
            4'd6:    note = CNT_W'(113636);
            4'd7:    note = CNT_W'(101238);
            4'd8:    note = CNT_W'(95556);
            default: note = '0;
        endcase
    end

    assign tone_t = bus.tone_en ? note : '0;

    // >= rather than == so a shorter note arriving mid-count wraps at once instead of overrunning.
    always_comb begin
        tone_cnt_d = tone_cnt_q + 1'b1;
        speaker_d  = speaker_q;
        if (tone_t == '0) begin
            tone_cnt_d = '0;
            speaker_d  = 1'b0;
        end else if (tone_cnt_q >= tone_t - CNT_W'(1)) begin
            tone_cnt_d = '0;
            speaker_d  = ~speaker_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q      <= SEL_NONE;
            mem_loc_q  <= '0;
            tone_cnt_q <= '0;
            speaker_q  <= 1'b0;
            kclk_q     <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            mem_loc_q  <= mem_loc_d;
            tone_cnt_q <= tone_cnt_d;
            speaker_q  <= speaker_d;
            kclk_q     <= ~kclk_q;
        end
    end

    assign bus.kclk     = kclk_q;
    assign bus.note     = note;
    assign bus.duration = duration;
    assign bus.mem_loc  = mem_loc_q;
    assign bus.notecase = notecase;
    assign bus.start    = start;
    assign bus.speaker  = speaker_q;
endmodule

// File: tb/tb_music_box_tone_gen.sv
// Directed bench for music_box_tone_gen: song ROM vector table plus reset/select/tone sequences.
module tb_music_box_tone_gen;
    logic clk;
    logic rst_n;
    int   errs;
    int   checks;

    music_box_tone_gen_if bus ();

    music_box_tone_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;      // {song3, song2, song1}
        int         pulses;
        int         loc;
        int         nc;
        int         note;
        int         dur;
        int         st;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_sel(input logic [2:0] s);
        bus.song1 = s[0];
        bus.song2 = s[1];
        bus.song3 = s[2];
    endtask

    task automatic pulse(input int n);
        repeat (n) begin
            bus.note_done = 1'b1;
            @(negedge clk);
            bus.note_done = 1'b0;
            @(negedge clk);
        end
    endtask

    // Deselect for a cycle, select, let the select register settle, then advance.
    task automatic go_to(input logic [2:0] s, input int n);
        @(negedge clk);
        set_sel(3'b000);
        @(negedge clk);
        set_sel(s);
        tick(2);
        pulse(n);
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        rst_n  = 1'b0;
        set_sel(3'b000);
        bus.note_done = 1'b0;
        bus.tone_en   = 1'b0;

        vq.push_back('{3'b001,  0,  0, 1, 191109, 1, 1});
        vq.push_back('{3'b001,  6,  6, 7, 101238, 1, 1});
        vq.push_back('{3'b001,  7,  7, 8,  95556, 1, 1});
        vq.push_back('{3'b001,  8,  8, 8,  95556, 1, 1});
        vq.push_back('{3'b001, 15, 15, 1, 191109, 1, 1});
        vq.push_back('{3'b001, 20, 20, 5, 127550, 1, 1});
        vq.push_back('{3'b001, 32,  0, 1, 191109, 1, 1});
        vq.push_back('{3'b010,  4,  4, 6, 113636, 0, 1});
        vq.push_back('{3'b010,  6,  6, 5, 127550, 2, 1});
        vq.push_back('{3'b010,  7,  7, 0,      0, 3, 1});
        vq.push_back('{3'b010,  9,  9, 4, 143172, 0, 1});
        vq.push_back('{3'b010, 11, 11, 3, 151685, 0, 1});
        vq.push_back('{3'b010, 12, 12, 2, 170265, 0, 1});
        vq.push_back('{3'b010, 22, 22, 5, 127550, 2, 1});
        vq.push_back('{3'b010, 31, 31, 0,      0, 3, 1});
        vq.push_back('{3'b100,  0,  0, 5, 127550, 0, 1});
        vq.push_back('{3'b100,  3,  3, 3, 151685, 0, 1});
        vq.push_back('{3'b100, 31, 31, 3, 151685, 3, 1});
        vq.push_back('{3'b101,  2,  2, 3, 151685, 1, 1});
        vq.push_back('{3'b110,  1,  1, 1, 191109, 0, 1});
        vq.push_back('{3'b000,  3,  0, 0,      0, 0, 0});

        // Reset state
        #23;
        chk("rst_kclk",    int'(bus.kclk), 0);
        chk("rst_mem_loc", int'(bus.mem_loc), 0);
        chk("rst_speaker", int'(bus.speaker), 0);
        chk("rst_note",    int'(bus.note), 0);
        chk("rst_start",   int'(bus.start), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Song ROM table
        foreach (vq[i]) begin
            go_to(vq[i].sel, vq[i].pulses);
            chk($sformatf("v%0d_mem_loc", i),  int'(bus.mem_loc),  vq[i].loc);
            chk($sformatf("v%0d_notecase", i), int'(bus.notecase), vq[i].nc);
            chk($sformatf("v%0d_note", i),     int'(bus.note),     vq[i].note);
            chk($sformatf("v%0d_duration", i), int'(bus.duration), vq[i].dur);
            chk($sformatf("v%0d_start", i),    int'(bus.start),    vq[i].st);
        end

        // Song 1 stepping with wrap, pulses 100 cycles apart
        go_to(3'b001, 0);
        bus.tone_en = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            bus.note_done = 1'b1;
            @(negedge clk);
            bus.note_done = 1'b0;
            tick(99);
            chk($sformatf("step%0d_mem_loc", i), int'(bus.mem_loc), i % 32);
        end
        bus.tone_en = 1'b0;

        // Priority / select change swallowing note_done
        go_to(3'b010, 5);
        chk("pri_pre_loc", int'(bus.mem_loc), 5);
        bus.song1     = 1'b1;
        bus.note_done = 1'b1;
        @(negedge clk);
        bus.note_done = 1'b0;
        chk("pri_loc", int'(bus.mem_loc), 0);
        chk("pri_nc",  int'(bus.notecase), 1);
        tick(1);
        chk("pri_hold_loc", int'(bus.mem_loc), 0);
        pulse(1);
        chk("pri_adv_loc", int'(bus.mem_loc), 1);

        // Deselect
        bus.tone_en = 1'b1;
        set_sel(3'b000);
        tick(1);
        chk("desel_start",   int'(bus.start), 0);
        chk("desel_loc",     int'(bus.mem_loc), 0);
        chk("desel_note",    int'(bus.note), 0);
        chk("desel_dur",     int'(bus.duration), 0);
        chk("desel_speaker", int'(bus.speaker), 0);
        pulse(2);
        chk("desel_pulse_loc", int'(bus.mem_loc), 0);

        // Rest step holds the speaker low
        go_to(3'b010, 7);
        chk("rest_nc",  int'(bus.notecase), 0);
        chk("rest_dur", int'(bus.duration), 3);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("rest_speaker", int'(bus.speaker), 0);
            chk("rest_cnt",     int'(dut.tone_cnt_q), 0);
        end

        // Tone divider on A4 (113636): counter preloaded near terminal count
        bus.tone_en = 1'b0;
        go_to(3'b010, 4);
        chk("tone_note", int'(bus.note), 113636);
        bus.tone_en = 1'b1;
        tick(100);
        chk("tone_cnt100", int'(dut.tone_cnt_q), 100);
        chk("tone_spk100", int'(bus.speaker), 0);
        force dut.tone_cnt_q = 20'd113633;
        #1 release dut.tone_cnt_q;
        tick(2);
        chk("tone_spk_pre", int'(bus.speaker), 0);
        tick(1);
        chk("tone_spk_rise", int'(bus.speaker), 1);
        chk("tone_cnt_wrap", int'(dut.tone_cnt_q), 0);
        force dut.tone_cnt_q = 20'd113633;
        #1 release dut.tone_cnt_q;
        tick(2);
        chk("tone_spk_hold", int'(bus.speaker), 1);
        tick(1);
        chk("tone_spk_fall", int'(bus.speaker), 0);
        force dut.tone_cnt_q = 20'd120000;
        #1 release dut.tone_cnt_q;
        tick(1);
        chk("tone_overrun_spk", int'(bus.speaker), 1);
        chk("tone_overrun_cnt", int'(dut.tone_cnt_q), 0);
        bus.tone_en = 1'b0;
        tick(1);
        chk("tone_off_spk", int'(bus.speaker), 0);
        chk("tone_off_cnt", int'(dut.tone_cnt_q), 0);

        // Mid-tone asynchronous reset on F4 (song1 step 3)
        go_to(3'b001, 3);
        bus.tone_en = 1'b1;
        force dut.tone_cnt_q = 20'd143171;
        #1 release dut.tone_cnt_q;
        tick(1);
        chk("mrst_pre_spk", int'(bus.speaker), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_speaker", int'(bus.speaker), 0);
        chk("mrst_kclk",    int'(bus.kclk), 0);
        chk("mrst_loc",     int'(bus.mem_loc), 0);
        chk("mrst_cnt",     int'(dut.tone_cnt_q), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            chk($sformatf("kclk_%0d", i), int'(bus.kclk), i % 2);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/music_box_tone_gen.md
Name: music_box_tone_gen

Overview:
Tone and song-playback core of the keyboard music box.
- Divides the 100 MHz system clock into a 50 MHz keyboard-receiver clock.
- Holds three 32-step songs and steps through the selected one on each note-done pulse.
- Emits a 20-bit half-period count for the current step.
- Generates a square wave on the speaker output from that count.
- Sits between the note-duration timer (supplies note_done / tone_en) and the board speaker pin.

Parameters:
- SONG_LEN, 32, steps per song; the address is 5 bits and wraps.
- CNT_W, 20, width of the half-period count.

Ports:
- clk  in  1  100 MHz system clock.
- rst_n  in  1  Reset, active-low, asynchronous. All state is cleared on assertion and released synchronously to clk.
- song1  in  1  Song 1 select; highest priority.
- song2  in  1  Song 2 select.
- song3  in  1  Song 3 select; lowest priority.
- note_done  in  1  One-cycle pulse that advances to the next step.
- tone_en  in  1  1 = sound allowed; 0 forces silence.
- kclk  out  1  clk/2 clock for the PS/2 receiver.
- note  out  20  Half-period count (in clk cycles) of the current step; 0 = rest.
- duration  out  2  Duration code of the current step, for the duration timer.
- mem_loc  out  5  Current step address.
- notecase  out  4  Current pitch index.
- start  out  1  High when any song is selected.
- speaker  out  1  Square-wave audio output.

Behaviour:
Reset values: kclk=0, mem_loc=0, speaker=0, tone counter=0. The combinational outputs follow from mem_loc=0.

kclk:
- Toggles on every clk rising edge, so it is 50 MHz at 50% duty.

Song select:
- start = song1|song2|song3.
- Active song = song1 if set, else song2 if set, else song3.
- Selected-song code is registered each cycle.
- If the code differs from the previous cycle (including going to none): mem_loc <= 0 in that cycle, and that cycle's note_done is ignored.

Sequencing:
- When start=1 and note_done=1 (and no select change that cycle): mem_loc <= mem_loc+1, wrapping 31->0.
- When start=0: mem_loc is held at 0.

Pitch index:
- notecase is combinational from (active song, mem_loc); notecase=0 when start=0.
- Indices: 0 rest, 1 C4, 2 D4, 3 E4, 4 F4, 5 G4, 6 A4, 7 B4, 8 C5; 9-15 are treated as rest.

Note table (note output):
- 1 C4 = 191109
- 2 D4 = 170265
- 3 E4 = 151685
- 4 F4 = 143172
- 5 G4 = 127550
- 6 A4 = 113636
- 7 B4 = 101238
- 8 C5 = 95556
- Rest = 0.

Song contents, indexed by step:
- Song1:
  - Steps 0-7 = 1..8; steps 8-15 = 8..1; steps 16-31 repeat 0-15.
  - duration = 1 for all steps.
- Song2 (16-step pattern, repeated for steps 16-31):
  - Notecases: 1,1,5,5,6,6,5,0,4,4,3,3,2,2,1,0.
  - duration = 2 on steps 6 and 14 (and 22, 30); 3 on rest steps; 0 otherwise.
- Song3:
  - Even steps = 5, odd steps = 3.
  - duration = 0, except step 31 = 3.
- No song selected: duration = 0.

Tone divider:
- Effective count T = tone_en ? note : 0.
- If T==0: counter <= 0 and speaker <= 0.
- Otherwise counter increments each clk. When counter >= T-1: counter <= 0 and speaker toggles.
- Speaker period = 2*T clk cycles (C4 ≈ 261.6 Hz).
- A mid-note change of T takes effect immediately. The >= compare prevents overrun when T decreases.

Simultaneous events:
- Reset dominates everything.
- A select change dominates note_done.
- A wrap at step 31 with note_done goes to 0.

Test Plan:
1. Reset: assert rst_n=0 mid-tone -> speaker=0, kclk=0, mem_loc=0 immediately. After release, kclk toggles every cycle (period 20 ns).
2. Song 1 stepping: song1=1, tone_en=1, note_done pulse every 100 cycles.
   - mem_loc goes 0,1,2…
   - notecase 1..8 then 8..1.
   - note = 191109 at step 0 and 95556 at step 7.
   - After the 32nd pulse, mem_loc wraps to 0.
3. Tone period: note=113636 (song2 step 4), tone_en=1 -> speaker toggles every 113636 cycles.
   - Then set tone_en=0 -> speaker=0 the next cycle and the counter clears.
4. Priority and select change: song2=1 at mem_loc=5, then assert song1 with a simultaneous note_done.
   - mem_loc -> 0; that note_done is ignored; notecase=1.
5. Deselect: drop all song inputs -> start=0, mem_loc=0, note=0, duration=0, speaker=0.
   - note_done pulses cause no change.
6. Rest step: song2 step 7 -> notecase 0, note 0, duration 3, speaker held 0.
